// File: rtl/spi_bridge.sv
// SPI mode-0 slave front end: synchronises sclk/cs_n/mosi into clk, deserialises
// MOSI into bytes (byte_sync/data_in) and serialises the decoder's data_out onto MISO.
//
// state  | meaning
// IDLE   | deselected; bit counter cleared, sclk/mosi ignored, miso low
// ACTIVE | frame in progress; shifting on sclk edges
module spi_bridge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       byte_sync,
  output logic [7:0] data_in,
  input  logic [7:0] data_out
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_d, cs_d, mosi_d;
  logic       sclk_rise, sclk_fall, cs_fall, cs_rise;
  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] rx_shift, tx_shift;
  logic       bs_d1;

  // Synchronisers reset to the pins' idle levels so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Edge pulses are registered; mosi_d keeps the data bit aligned with sclk_rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      mosi_d    <= 1'b0;
      sclk_rise <= 1'b0;
      sclk_fall <= 1'b0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      mosi_d    <= mosi_s;
      sclk_rise <= sclk_s & ~sclk_d;
      sclk_fall <= ~sclk_s & sclk_d;
      cs_fall   <= ~cs_s & cs_d;
      cs_rise   <= cs_s & ~cs_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      rx_shift  <= 8'h00;
      tx_shift  <= 8'h00;
      data_in   <= 8'h00;
      byte_sync <= 1'b0;
      bs_d1     <= 1'b0;
    end else begin
      byte_sync <= 1'b0;
      bs_d1     <= byte_sync;
      case (state)
        IDLE: begin
          bit_cnt <= 3'd0;
          if (cs_fall) begin
            state    <= ACTIVE;
            tx_shift <= data_out;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            // Partial byte is discarded and any pending reload is dropped.
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end else begin
            if (sclk_rise && !cs_s) begin
              rx_shift <= {rx_shift[6:0], mosi_d};
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_in   <= {rx_shift[6:0], mosi_d};
                byte_sync <= 1'b1;
              end
            end
            // Reload two cycles after byte_sync so the decoder's registered output has settled.
            if (bs_d1) begin
              tx_shift <= data_out;
            end else if (sclk_fall && !cs_s && bit_cnt != 3'd0) begin
              tx_shift <= {tx_shift[6:0], 1'b0};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign miso = (state == ACTIVE) && !cs_s && tx_shift[7];

endmodule

// File: tb/tb_spi_bridge.sv
// Directed bench for spi_bridge: mode-0 master model, data_in scoreboard queue,
// MISO readback and byte_sync latency/width checks.
module tb_spi_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, cs_n, mosi;
  logic       miso, byte_sync;
  logic [7:0] data_in, data_out;

  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         rise8_cyc = 0;
  int         sync_cnt = 0;
  int         sync_base;
  logic       prev_bs  = 1'b0;
  logic [7:0] dout_next;
  logic [7:0] rx;
  logic [7:0] exp_q[$];

  spi_bridge #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .byte_sync(byte_sync),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every byte_sync pops one expected byte and plays the decoder.
  always @(posedge clk) begin
    #1;
    if (rst_n === 1'b1 && byte_sync === 1'b1) begin
      check("bs_width", {15'd0, prev_bs}, 16'd0);
      check("bs_latency", 16'(cyc - rise8_cyc), 16'(SYNC_STAGES + 2));
      check("bs_expected", 16'(exp_q.size() != 0), 16'd1);
      if (exp_q.size() != 0) check("data_in", {8'd0, data_in}, {8'd0, exp_q.pop_front()});
      sync_cnt++;
      data_out = dout_next;
    end
    prev_bs = byte_sync;
  end

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit push,
                          output logic [7:0] rxd);
    rxd = 8'h00;
    if (push) exp_q.push_back(tx);
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rxd = {rxd[6:0], miso};
      sclk = 1'b1;
      if (i == 7) rise8_cyc = cyc;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic select();
    cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic deselect();
    repeat (HALF) @(negedge clk);
    cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    data_out = 8'h00; dout_next = 8'h00;

    // Reset held with pins toggling
    repeat (20) begin
      @(negedge clk);
      sclk = 1'($urandom_range(0, 1));
      cs_n = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_byte_sync", {15'd0, byte_sync}, 16'd0);
      check("rst_data_in", {8'd0, data_in}, 16'h0000);
      check("rst_miso", {15'd0, miso}, 16'd0);
    end
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      sclk = 1'($urandom_range(0, 1));
      mosi = 1'($urandom_range(0, 1));
      check("idle_miso", {15'd0, miso}, 16'd0);
    end
    sclk = 1'b0;
    repeat (HALF) @(negedge clk);
    check("idle_no_sync", 16'(sync_cnt), 16'd0);
    check("idle_data_in", {8'd0, data_in}, 16'h0000);

    // Two-byte write frame
    sync_base = sync_cnt;
    select();
    spi_bits(8'h85, 8, 1'b1, rx);
    spi_bits(8'hA5, 8, 1'b1, rx);
    deselect();
    check("write_pulses", 16'(sync_cnt - sync_base), 16'd2);
    check("write_last", {8'd0, data_in}, 16'h00A5);

    // Readback: 0x3C at select, then 0xC3 reloaded after the first byte
    data_out = 8'h3C; dout_next = 8'hC3;
    @(negedge clk);
    select();
    spi_bits(8'h01, 8, 1'b1, rx);
    check("miso_byte0", {8'd0, rx}, 16'h003C);
    spi_bits(8'h00, 8, 1'b1, rx);
    check("miso_byte1", {8'd0, rx}, 16'h00C3);
    deselect();
    check("deselect_miso", {15'd0, miso}, 16'd0);

    // Aborted byte keeps prior data_in
    sync_base = sync_cnt;
    select();
    spi_bits(8'hFF, 5, 1'b0, rx);
    deselect();
    check("abort_data_in", {8'd0, data_in}, 16'h0000);
    check("abort_no_sync", 16'(sync_cnt - sync_base), 16'd0);
    select();
    spi_bits(8'h12, 8, 1'b1, rx);
    deselect();
    check("abort_pulses", 16'(sync_cnt - sync_base), 16'd1);
    check("abort_next", {8'd0, data_in}, 16'h0012);

    // Reset after bit 4 of a byte
    sync_base = sync_cnt;
    select();
    spi_bits(8'hA5, 4, 1'b0, rx);
    rst_n = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_data_in", {8'd0, data_in}, 16'h0000);
    check("midrst_miso", {15'd0, miso}, 16'd0);
    rst_n = 1'b1;
    repeat (HALF) @(negedge clk);
    check("midrst_no_sync", 16'(sync_cnt - sync_base), 16'd0);
    select();
    spi_bits(8'h7E, 8, 1'b1, rx);
    deselect();
    check("midrst_pulses", 16'(sync_cnt - sync_base), 16'd1);
    check("midrst_data", {8'd0, data_in}, 16'h007E);

    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
